// File: rtl/frame_swap_controller_pkg.sv
// Shared types for the framebuffer swap controller and its frame-end detector.
// Holds the scan-path address/mask types, the frame counter type, the swap
// FSM state encoding and a small helper that recognises the last bit-plane.
package types;

    localparam int ROW_ADDR_WIDTH   = 5;
    localparam int BRIGHTNESS_WIDTH = 8;
    localparam int FRAME_CNT_WIDTH  = 8;

    typedef logic [ROW_ADDR_WIDTH-1:0]   row_subpanel_addr_t;
    typedef logic [BRIGHTNESS_WIDTH-1:0] brightness_level_t;
    typedef logic [FRAME_CNT_WIDTH-1:0]  frame_count_t;

    // Fixed state codes, kept as plain constants so older code that compares
    // against raw values keeps working.
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_ACK_HIGH   = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        WAIT_FRAME = ST_WAIT_FRAME,
        ACK_HIGH   = ST_ACK_HIGH
    } swap_state_t;

    // The scan walks bit-planes from MSB down, so mask == 1 is the final plane.
    function automatic logic is_last_plane(input brightness_level_t mask);
        return mask == brightness_level_t'(1);
    endfunction

endpackage

// File: rtl/frame_end_detect.sv
// Frame-end detector.
// Flags the rising edge of row_latch on the last row while the last
// bit-plane is being shown, and produces a registered one-cycle frame_tick.
// Ports:
//   clk_in          system clock, posedge
//   reset           synchronous active-high reset
//   row_latch       row latch strobe from the scan block
//   row_address     current scan row
//   brightness_mask current bit-plane mask
//   frame_end       raw (combinational) frame-end condition
//   frame_tick      frame_end delayed by one clock
module frame_end_detect
    import types::*;
(
    input  logic               clk_in,
    input  logic               reset,
    input  logic               row_latch,
    input  row_subpanel_addr_t row_address,
    input  brightness_level_t  brightness_mask,
    output logic               frame_end,
    output logic               frame_tick
);

    logic row_latch_q;

    // Only the first cycle of a latch strobe counts, so a strobe stretched by
    // the scan block cannot produce two frame ends.
    assign frame_end = row_latch && !row_latch_q
                    && (row_address == '1)
                    && is_last_plane(brightness_mask);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            row_latch_q <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            row_latch_q <= row_latch;
            frame_tick  <= frame_end;
        end
    end

endmodule

// File: rtl/frame_swap_controller.sv
// Double-buffered framebuffer swap controller.
// The writer requests a bank swap with a 4-phase level handshake
// (swap_req/swap_ack). With VSYNC_SWAP=1 the swap waits for the end of the
// current frame so the scan path never shows a torn image; with VSYNC_SWAP=0
// it happens on the next clock.
// Ports:
//   clk_in, reset     clock and synchronous active-high reset
//   row_latch, row_address, brightness_mask   scan position inputs
//   swap_req / swap_ack                       writer handshake
//   read_bank / write_bank                    current bank ownership
//   frame_tick, frame_count                   frame pulse and wrapping counter
//   swap_pending                              swap waiting for frame boundary
//   protocol_error                            sticky handshake violation
module frame_swap_controller
    import types::*;
#(
    parameter int VSYNC_SWAP = 1,
    parameter int _UNUSED    = 0
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               row_latch,
    input  row_subpanel_addr_t row_address,
    input  brightness_level_t  brightness_mask,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               read_bank,
    output logic               write_bank,
    output logic               frame_tick,
    output frame_count_t       frame_count,
    output logic               swap_pending,
    output logic               protocol_error
);

    logic        frame_end;
    swap_state_t state;
    swap_state_t state_next;
    logic        do_toggle;
    logic        set_error;

    frame_end_detect u_frame_end_detect (
        .clk_in          (clk_in),
        .reset           (reset),
        .row_latch       (row_latch),
        .row_address     (row_address),
        .brightness_mask (brightness_mask),
        .frame_end       (frame_end),
        .frame_tick      (frame_tick)
    );

    // Handshake FSM. A writer that drops its request while waiting aborts the
    // swap, and that abort wins over a frame end on the same cycle. Leaving
    // ACK_HIGH requires swap_req low, so IDLE only ever sees a fresh request;
    // a writer that keeps swap_req high after being acknowledged and lets a
    // frame boundary pass is trying to reuse the old handshake, which is
    // flagged instead of being granted a second swap.
    always_comb begin
        state_next = state;
        do_toggle  = 1'b0;
        set_error  = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req) begin
                    if (VSYNC_SWAP != 0) begin
                        state_next = WAIT_FRAME;
                    end else begin
                        do_toggle  = 1'b1;
                        state_next = ACK_HIGH;
                    end
                end
            end
            WAIT_FRAME: begin
                if (!swap_req) begin
                    state_next = IDLE;
                end else if (frame_end) begin
                    do_toggle  = 1'b1;
                    state_next = ACK_HIGH;
                end
            end
            ACK_HIGH: begin
                if (!swap_req) begin
                    state_next = IDLE;
                end else if (frame_end) begin
                    set_error = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state change; frame_count moves on the same edge frame_tick
    // rises.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state          <= IDLE;
            read_bank      <= 1'b0;
            swap_ack       <= 1'b0;
            swap_pending   <= 1'b0;
            frame_count    <= '0;
            protocol_error <= 1'b0;
        end else begin
            state        <= state_next;
            swap_ack     <= (state_next == ACK_HIGH);
            swap_pending <= (state_next == WAIT_FRAME);
            if (do_toggle) begin
                read_bank <= ~read_bank;
            end
            if (frame_end) begin
                frame_count <= frame_count + frame_count_t'(1);
            end
            if (set_error) begin
                protocol_error <= 1'b1;
            end
        end
    end

    assign write_bank = ~read_bank;

endmodule
